// File: rtl/axi4_lite_initiator.sv
// Single-outstanding AXI4-Lite initiator: turns one command into a read or
// write burst of one beat, returns the result, and flags stalled bus phases.
module axi4_lite_initiator #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_insn,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        timeout,
  output logic        mem_axi_awvalid,
  input  logic        mem_axi_awready,
  output logic [31:0] mem_axi_awaddr,
  output logic [2:0]  mem_axi_awprot,
  output logic        mem_axi_wvalid,
  input  logic        mem_axi_wready,
  output logic [31:0] mem_axi_wdata,
  output logic [3:0]  mem_axi_wstrb,
  input  logic        mem_axi_bvalid,
  output logic        mem_axi_bready,
  output logic        mem_axi_arvalid,
  input  logic        mem_axi_arready,
  output logic [31:0] mem_axi_araddr,
  output logic [2:0]  mem_axi_arprot,
  input  logic        mem_axi_rvalid,
  output logic        mem_axi_rready,
  input  logic [31:0] mem_axi_rdata
);

  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP} state_t;

  state_t          state_reg, state_next;
  logic [31:0]     addr_reg, wdata_reg, rdata_reg;
  logic [3:0]      wstrb_reg;
  logic            insn_reg;
  logic            aw_done_reg, w_done_reg;
  logic            timeout_reg;
  logic [CW-1:0]   wait_cnt_reg, wait_cnt_next;
  logic            waiting;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cmd_valid) state_next = cmd_write ? WR_REQ : RD_ADDR;
      RD_ADDR: if (mem_axi_arready) state_next = RD_DATA;
      RD_DATA: if (mem_axi_rvalid) state_next = RESP;
      // A ready seen in the same cycle as the other channel's completion counts.
      WR_REQ:  if ((aw_done_reg || mem_axi_awready) && (w_done_reg || mem_axi_wready))
                 state_next = WR_RESP;
      WR_RESP: if (mem_axi_bvalid) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready       = (state_reg == IDLE);
    rsp_valid       = (state_reg == RESP);
    mem_axi_arvalid = (state_reg == RD_ADDR);
    mem_axi_rready  = (state_reg == RD_DATA);
    mem_axi_awvalid = (state_reg == WR_REQ) && !aw_done_reg;
    mem_axi_wvalid  = (state_reg == WR_REQ) && !w_done_reg;
    mem_axi_bready  = (state_reg == WR_RESP);
  end

  assign mem_axi_araddr = addr_reg;
  assign mem_axi_arprot = {insn_reg, 2'b00};
  assign mem_axi_awaddr = addr_reg;
  assign mem_axi_awprot = 3'b000;
  assign mem_axi_wdata  = wdata_reg;
  assign mem_axi_wstrb  = wstrb_reg;
  assign rsp_rdata      = rdata_reg;
  assign timeout        = timeout_reg;

  assign waiting = (state_reg == RD_ADDR) || (state_reg == RD_DATA) ||
                   (state_reg == WR_REQ)  || (state_reg == WR_RESP);

  always_comb begin
    wait_cnt_next = '0;
    if (state_next == state_reg && waiting) begin
      wait_cnt_next = wait_cnt_reg;
      if (wait_cnt_reg != '1) wait_cnt_next = wait_cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg     <= '0;
      wdata_reg    <= '0;
      wstrb_reg    <= '0;
      insn_reg     <= 1'b0;
      rdata_reg    <= '0;
      aw_done_reg  <= 1'b0;
      w_done_reg   <= 1'b0;
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
      if (TIMEOUT != 0 && waiting && wait_cnt_next == TIMEOUT_CNT)
        timeout_reg <= 1'b1;
      case (state_reg)
        IDLE: if (cmd_valid) begin
          addr_reg    <= cmd_addr;
          wdata_reg   <= cmd_wdata;
          wstrb_reg   <= cmd_wstrb;
          insn_reg    <= cmd_insn;
          aw_done_reg <= 1'b0;
          w_done_reg  <= 1'b0;
        end
        WR_REQ: begin
          if (mem_axi_awready) aw_done_reg <= 1'b1;
          if (mem_axi_wready)  w_done_reg  <= 1'b1;
        end
        RD_DATA: if (mem_axi_rvalid) rdata_reg <= mem_axi_rdata;
        WR_RESP: if (mem_axi_bvalid) rdata_reg <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_initiator.sv
// Directed bench for axi4_lite_initiator: behavioural AXI slave with per-channel
// delays, expected responses queued at issue time and checked by a monitor.
module tb_axi4_lite_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_insn;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        timeout;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

  axi4_lite_initiator #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_insn(cmd_insn), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_wstrb(cmd_wstrb), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .timeout(timeout),
    .mem_axi_awvalid(awvalid), .mem_axi_awready(awready),
    .mem_axi_awaddr(awaddr), .mem_axi_awprot(awprot),
    .mem_axi_wvalid(wvalid), .mem_axi_wready(wready),
    .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
    .mem_axi_bvalid(bvalid), .mem_axi_bready(bready),
    .mem_axi_arvalid(arvalid), .mem_axi_arready(arready),
    .mem_axi_araddr(araddr), .mem_axi_arprot(arprot),
    .mem_axi_rvalid(rvalid), .mem_axi_rready(rready), .mem_axi_rdata(rdata)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];

  int ar_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0, r_delay = 0;
  logic [31:0] r_value = '0;
  int ar_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [2:0]  cap_arprot, cap_awprot;
  logic [3:0]  cap_wstrb;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Slave channels: ready/valid asserted on a negedge after the programmed delay,
  // dropped on the following negedge (the handshake edge lies in between).
  initial begin : p_ar
    int wt;
    wt = 0; arready = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin arready = 1'b0; wt = 0; end
      else if (arready) arready = 1'b0;
      else if (arvalid) begin
        if (wt >= ar_delay) begin
          arready = 1'b1; ar_hs++; cap_araddr = araddr; cap_arprot = arprot; wt = 0;
        end else wt++;
      end else wt = 0;
    end
  end

  initial begin : p_aw
    int wt;
    wt = 0; awready = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin awready = 1'b0; wt = 0; end
      else if (awready) awready = 1'b0;
      else if (awvalid) begin
        if (wt >= aw_delay) begin
          awready = 1'b1; aw_hs++; cap_awaddr = awaddr; cap_awprot = awprot; wt = 0;
        end else wt++;
      end else wt = 0;
    end
  end

  initial begin : p_w
    int wt;
    wt = 0; wready = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin wready = 1'b0; wt = 0; end
      else if (wready) wready = 1'b0;
      else if (wvalid) begin
        if (wt >= w_delay) begin
          wready = 1'b1; w_hs++; cap_wdata = wdata; cap_wstrb = wstrb; wt = 0;
        end else wt++;
      end else wt = 0;
    end
  end

  initial begin : p_b
    int wt;
    wt = 0; bvalid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin bvalid = 1'b0; wt = 0; end
      else if (bvalid) bvalid = 1'b0;
      else if (bready) begin
        if (wt >= b_delay) begin bvalid = 1'b1; b_hs++; wt = 0; end
        else wt++;
      end else wt = 0;
    end
  end

  initial begin : p_r
    int wt;
    wt = 0; rvalid = 1'b0; rdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin rvalid = 1'b0; wt = 0; end
      else if (rvalid) begin rvalid = 1'b0; rdata = '0; end
      else if (rready) begin
        if (wt >= r_delay) begin rvalid = 1'b1; rdata = r_value; wt = 0; end
        else wt++;
      end else wt = 0;
    end
  end

  // Monitor: a response handshake is pending whenever both are high mid-cycle.
  initial begin : p_mon
    forever begin
      @(negedge clk);
      #1;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected actual=%h required=none", rsp_rdata);
        end else check("rsp_rdata", rsp_rdata, exp_q.pop_front());
      end
    end
  end

  task automatic issue(input logic wr, input logic insn, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s, input logic [31:0] exp);
    int t;
    t = 0;
    cmd_write = wr; cmd_insn = insn; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    cmd_valid = 1'b1;
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL cmd_accept actual=0 required=1");
      cmd_valid = 1'b0;
      return;
    end
    exp_q.push_back(exp);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin @(negedge clk); t++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rsp_timeout actual=%0d pending required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin : p_main
    int n0, n1, c, t;
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_insn = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_timeout", timeout, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_rready", rready, 0);

    // Read, arready after 2 cycles, instruction fetch
    ar_delay = 2; r_delay = 0; r_value = 32'hDEADBEEF;
    n0 = ar_hs;
    issue(1'b0, 1'b1, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF);
    wait_done();
    check("rd_arprot", 32'(cap_arprot), 32'h4);
    check("rd_araddr", cap_araddr, 32'h100);
    check("rd_ar_hs", ar_hs - n0, 1);

    // Write, wready 3 cycles before awready
    aw_delay = 3; w_delay = 0; b_delay = 1;
    n0 = b_hs;
    issue(1'b1, 1'b0, 32'h200, 32'h12345678, 4'b0011, 32'h0);
    @(negedge clk);
    check("wr_wvalid_dropped", wvalid, 0);
    check("wr_awvalid_held", awvalid, 1);
    wait_done();
    check("wr_b_hs", b_hs - n0, 1);
    check("wr_awaddr", cap_awaddr, 32'h200);
    check("wr_awprot", 32'(cap_awprot), 0);
    check("wr_wdata", cap_wdata, 32'h12345678);
    check("wr_wstrb", 32'(cap_wstrb), 32'h3);

    // Same-cycle AW/W handshake, bvalid next cycle
    aw_delay = 0; w_delay = 0; b_delay = 0;
    n0 = aw_hs; n1 = w_hs;
    issue(1'b1, 1'b0, 32'h300, 32'hA5A5A5A5, 4'hF, 32'h0);
    c = cyc; t = 0;
    while (!rsp_valid && t < 20) begin @(negedge clk); t++; end
    check("same_cycle_latency", cyc - c, 2);
    wait_done();
    check("same_cycle_aw_hs", aw_hs - n0, 1);
    check("same_cycle_w_hs", w_hs - n1, 1);

    // Response back-pressure, stray command ignored
    ar_delay = 0; r_delay = 1; r_value = 32'hCAFEF00D;
    rsp_ready = 1'b0;
    issue(1'b0, 1'b0, 32'h400, 32'h0, 4'h0, 32'hCAFEF00D);
    t = 0;
    while (!rsp_valid && t < 20) begin @(negedge clk); t++; end
    n0 = aw_hs;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h444;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
      check("bp_cmd_ready", cmd_ready, 0);
      @(negedge clk);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    wait_done();
    repeat (3) @(negedge clk);
    check("bp_cmd_ignored", aw_hs - n0, 0);
    check("bp_arprot", 32'(cap_arprot), 0);
    check("pre_timeout", timeout, 0);

    // Timeout: arready withheld 20 cycles, TIMEOUT = 8
    ar_delay = 20; r_delay = 0; r_value = 32'h0BADC0DE;
    n0 = ar_hs;
    issue(1'b0, 1'b1, 32'h500, 32'h0, 4'h0, 32'h0BADC0DE);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check("to_arvalid_held", arvalid, 1);
      if (i == 7) check("to_before", timeout, 0);
      if (i == 8) check("to_set", timeout, 1);
    end
    wait_done();
    check("to_sticky", timeout, 1);
    check("to_ar_hs", ar_hs - n0, 1);

    // Asynchronous reset in the middle of a write request
    aw_delay = 50; w_delay = 50;
    issue(1'b1, 1'b0, 32'h600, 32'h87654321, 4'hF, 32'h0);
    repeat (3) @(negedge clk);
    check("mid_awvalid", awvalid, 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_awvalid", awvalid, 0);
    check("arst_wvalid", wvalid, 0);
    check("arst_awaddr", awaddr, 0);
    check("arst_wdata", wdata, 0);
    check("arst_wstrb", 32'(wstrb), 0);
    check("arst_timeout", timeout, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    ar_delay = 1; r_delay = 0; r_value = 32'h5A5AA5A5;
    aw_delay = 0; w_delay = 0;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);
    issue(1'b0, 1'b0, 32'h700, 32'h0, 4'h0, 32'h5A5AA5A5);
    wait_done();
    check("post_rst_araddr", cap_araddr, 32'h700);
    check("post_rst_arprot", 32'(cap_arprot), 0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : p_watchdog
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
